// File: rtl/count_seq_ctrl.sv
// Purpose: sequences an external up/down counter from a load value to a terminal value and checks every step.
// Latency: ld one cycle after start; an N-step run pulses done N+3 cycles after start.
// Backpressure: none; start is ignored while a sequence is active, abort/reset return to idle.
module count_seq_ctrl #(
    parameter int WIDTH   = 4,
    parameter int MAX_ERR = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] prevcount,
    output logic             ld,
    output logic [WIDTH-1:0] load_data,
    output logic             en,
    output logic             up,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_LIM = 2'(MAX_ERR);

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] term_q;
    logic             chk_vld;
    logic             ld_q;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       err_cnt_q;

    logic [WIDTH-1:0] exp_cnt;
    logic             at_term;
    logic             step_err;
    logic [1:0]       err_cnt_inc;
    logic             err_limit;

    // Step checker: the counter must have moved exactly one position (mod 2^WIDTH) in the latched direction.
    always_comb begin
        at_term     = (count == term_q);
        exp_cnt     = dir_q ? (prevcount + WIDTH'(1)) : (prevcount - WIDTH'(1));
        step_err    = chk_vld && (state == S_RUN) && (count != exp_cnt);
        err_cnt_inc = (step_err && (err_cnt_q != 2'd3)) ? (err_cnt_q + 2'd1) : err_cnt_q;
        err_limit   = step_err && (err_cnt_inc >= ERR_LIM);
    end

    // Counter-facing outputs; en follows count combinationally and both strobes drop as soon as abort is seen.
    always_comb begin
        en        = (state == S_RUN) && !abort && !at_term;
        ld        = ld_q && !abort;
        up        = dir_q;
        load_data = load_q;
        busy      = busy_q;
        done      = done_q;
        err       = (err_cnt_q != 2'd0);
        err_cnt   = err_cnt_q;
    end

    // Sequencing FSM with registered status outputs; abort outranks every transition, error limit outranks terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            dir_q     <= 1'b0;
            load_q    <= '0;
            term_q    <= '0;
            chk_vld   <= 1'b0;
            ld_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_cnt_q <= 2'd0;
        end else begin
            chk_vld <= en;
            ld_q    <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start && !abort) begin
                        state     <= S_LOAD;
                        dir_q     <= up_dn;
                        load_q    <= load_val;
                        term_q    <= term_val;
                        err_cnt_q <= 2'd0;
                        ld_q      <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= S_RUN;
                        busy_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    err_cnt_q <= err_cnt_inc;
                    if (abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (err_limit) begin
                        state  <= S_ERR;
                        busy_q <= 1'b1;
                    end else if (at_term) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                S_ERR: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Purpose: randomized and directed checking of count_seq_ctrl against a step-walk reference and a counter model.
// Latency: expected ld/done events are queued with their cycle numbers and matched by a negedge monitor.
// Backpressure: n/a (bench).
module tb_count_seq_ctrl;

    localparam int W       = 4;
    localparam int MAX_ERR = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         up_dn = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] term_val = '0;
    logic [W-1:0] count = '0;
    logic [W-1:0] prevcount = '0;
    logic         ld;
    logic [W-1:0] load_data;
    logic         en;
    logic         up;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   err_cnt;

    count_seq_ctrl #(.WIDTH(W), .MAX_ERR(MAX_ERR)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .up_dn     (up_dn),
        .load_val  (load_val),
        .term_val  (term_val),
        .count     (count),
        .prevcount (prevcount),
        .ld        (ld),
        .load_data (load_data),
        .en        (en),
        .up        (up),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Edge counter: during the cycle that begins at edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc++;

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        int         kind;   // 0 = ld strobe, 1 = done pulse
        int         at;
        logic [3:0] data;
        logic [1:0] ecnt;
    } exp_t;

    exp_t expq[$];
    exp_t e;

    logic [15:0] fmask = '0;
    int          stepidx = 0;

    task automatic chk(input string name, input int act, input int req);
        ntot++;
        if (act == req) npass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every ld/done the DUT presents must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (ld) begin
                if (expq.size() == 0 || expq[0].kind != 0) begin
                    chk("ld unexpected", int'(ld), 0);
                end else begin
                    e = expq.pop_front();
                    chk("ld cycle", cyc, e.at);
                    chk("load_data", int'(load_data), int'(e.data));
                end
            end
            if (done) begin
                if (expq.size() == 0 || expq[0].kind != 1) begin
                    chk("done unexpected", int'(done), 0);
                end else begin
                    e = expq.pop_front();
                    chk("done cycle", cyc, e.at);
                    chk("done err_cnt", int'(err_cnt), int'(e.ecnt));
                    chk("done err", int'(err), int'(e.ecnt != 2'd0));
                end
            end
        end
    end

    // One clock: sample strobes before the edge, then move the counter model (optionally skipping a value).
    task automatic tick();
        logic         s_ld, s_en, s_up;
        logic [W-1:0] s_ldd;
        int           d;
        #1;
        s_ld = ld; s_en = en; s_up = up; s_ldd = load_data;
        @(posedge clk);
        #1;
        prevcount = count;
        if (s_ld) begin
            count   = s_ldd;
            stepidx = 0;
        end else if (s_en) begin
            stepidx++;
            d = (stepidx < 16 && fmask[stepidx]) ? 2 : 1;
            count = s_up ? count + W'(d) : count - W'(d);
        end
    endtask

    // Reference: walk the counter value arithmetically from load to terminal, counting faulty steps.
    function automatic void ref_walk(input logic d, input logic [3:0] lv, input logic [3:0] tv,
                                     input logic [15:0] m, output int nsteps, output int nerr,
                                     output int errstep);
        int v;
        int dd;
        v = int'(lv); nsteps = 0; nerr = 0; errstep = 0;
        while (v != int'(tv) && nsteps < 48) begin
            nsteps++;
            dd = (nsteps < 16 && m[nsteps]) ? 2 : 1;
            v  = d ? (v + dd) % 16 : (v - dd + 32) % 16;
            if (dd == 2) begin
                nerr++;
                if (nerr >= MAX_ERR) begin
                    errstep = nsteps;
                    break;
                end
            end
        end
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, " ld"}, int'(ld), 0);
        chk({tag, " en"}, int'(en), 0);
        chk({tag, " up"}, int'(up), 0);
        chk({tag, " load_data"}, int'(load_data), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " err"}, int'(err), 0);
        chk({tag, " err_cnt"}, int'(err_cnt), 0);
    endtask

    // One sequence with junk start pulses while busy; ERR outcomes are left by abort or by reset.
    task automatic run_seq(input logic d, input logic [3:0] lv, input logic [3:0] tv,
                           input logic [15:0] m, input bit use_reset);
        int   s, nsteps, nerr, errstep, end_e, sat;
        exp_t x;
        fmask = m;
        ref_walk(d, lv, tv, m, nsteps, nerr, errstep);
        sat = (nerr > 3) ? 3 : nerr;
        s = cyc + 1;
        start = 1'b1; up_dn = d; load_val = lv; term_val = tv;
        x.kind = 0; x.at = s; x.data = lv; x.ecnt = 2'd0;
        expq.push_back(x);
        if (errstep == 0) begin
            end_e = s + nsteps + 2;
            x.kind = 1; x.at = end_e; x.data = 4'd0; x.ecnt = 2'(sat);
            expq.push_back(x);
        end else begin
            end_e = s + errstep + 2;
        end
        tick();
        start = 1'b0;
        while (cyc < end_e + 1) begin
            if (cyc + 1 <= end_e && $urandom_range(0, 3) == 0) begin
                start    = 1'b1;
                up_dn    = 1'($urandom);
                load_val = 4'($urandom);
                term_val = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        if (errstep != 0) begin
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("err busy", int'(busy), 1);
                chk("err en", int'(en), 0);
                chk("err ld", int'(ld), 0);
                chk("err err_cnt", int'(err_cnt), MAX_ERR);
                chk("err err", int'(err), 1);
                tick();
            end
            if (use_reset) begin
                reset = 1'b1;
                abort = 1'b1;
                tick();
                reset = 1'b0;
                abort = 1'b0;
                #1;
                check_all_zero("reset from err");
            end else begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                #1;
                chk("abort from err busy", int'(busy), 0);
                chk("err_cnt held after abort", int'(err_cnt), MAX_ERR);
            end
        end
        tick();
        tick();
        chk("queue drained", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        logic [15:0] m;
        int          s;
        exp_t        x;

        // Reset outranks a concurrent start and abort.
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        repeat (3) tick();
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        #1;
        check_all_zero("after reset");

        run_seq(1'b1, 4'd3, 4'd7, 16'h0000, 1'b0);
        run_seq(1'b0, 4'd1, 4'd14, 16'h0000, 1'b0);
        run_seq(1'b1, 4'd0, 4'd8, 16'b0000_0000_0010_0100, 1'b0);
        run_seq(1'b1, 4'd0, 4'd12, 16'b0000_0000_0010_1010, 1'b0);
        run_seq(1'b1, 4'd9, 4'd9, 16'h0000, 1'b0);

        // Abort in the second RUN cycle: en drops at once, no done afterwards.
        fmask = '0;
        s = cyc + 1;
        start = 1'b1; up_dn = 1'b1; load_val = 4'd2; term_val = 4'd10;
        x.kind = 0; x.at = s; x.data = 4'd2; x.ecnt = 2'd0;
        expq.push_back(x);
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        #1;
        chk("en gated by abort", int'(en), 0);
        chk("busy before abort", int'(busy), 1);
        tick();
        abort = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort en", int'(en), 0);
        chk("abort ld", int'(ld), 0);
        repeat (4) tick();
        chk("abort queue drained", expq.size(), 0);
        expq.delete();

        run_seq(1'b0, 4'd15, 4'd2, 16'b0000_0000_0101_0100, 1'b1);

        for (int i = 0; i < 25; i++) begin
            m = '0;
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 2) == 0) m[$urandom_range(1, 15)] = 1'b1;
            run_seq(1'($urandom), 4'($urandom), 4'($urandom), m, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, counter datapath width in bits.
REQ-002 Parameter MAX_ERR, default 3, number of step errors that forces the ERR state (range 1..3).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a count sequence; honoured only in IDLE.
REQ-006 abort  input  1  terminate the sequence or clear ERR; returns to IDLE.
REQ-007 up_dn  input  1  direction, sampled with start: 1 = up, 0 = down.
REQ-008 load_val  input  WIDTH  initial counter value, sampled with start.
REQ-009 term_val  input  WIDTH  terminal counter value, sampled with start.
REQ-010 count  input  WIDTH  current value from the controlled counter.
REQ-011 prevcount  input  WIDTH  previous-cycle value from the controlled counter.
REQ-012 ld  output  1  counter load strobe.
REQ-013 load_data  output  WIDTH  value to load; valid while ld=1.
REQ-014 en  output  1  counter step enable.
REQ-015 up  output  1  counter direction; valid while en=1.
REQ-016 busy  output  1  high in LOAD, RUN and ERR.
REQ-017 done  output  1  one-cycle pulse on sequence completion.
REQ-018 err  output  1  high whenever err_cnt is non-zero.
REQ-019 err_cnt  output  2  saturating step-error count.

Function
REQ-020 FSM states: IDLE, LOAD, RUN, DONE, ERR; state is registered.
REQ-021 IDLE: start=1 and abort=0 -> LOAD next cycle; latch up_dn, load_val, term_val; clear err_cnt.
REQ-022 LOAD: ld=1 and load_data=latched load_val for exactly one cycle -> RUN.
REQ-023 RUN: en = (count != latched term_val), combinational; up = latched direction.
REQ-024 RUN: count == term_val -> DONE next cycle; en=0 in that cycle.
REQ-025 DONE: done=1 for one cycle -> IDLE.
REQ-026 Step check: chk_vld is a register equal to the previous cycle's en.
REQ-027 When chk_vld=1, an error exists if count != prevcount+1 (up) or count != prevcount-1 (down), modulo 2^WIDTH.
REQ-028 Wrap-around is legal: up step 15->0 and down step 0->15 (WIDTH=4) are not errors.
REQ-029 Each error cycle increments err_cnt by 1; err_cnt saturates at 3.
REQ-030 err_cnt reaching MAX_ERR while in RUN -> ERR next cycle; this takes priority over the terminal-count transition in REQ-024.
REQ-031 An error and terminal count in the same cycle with err_cnt below MAX_ERR: count the error and go to DONE.
REQ-032 ERR: ld=0, en=0, busy=1; leave only on abort=1 -> IDLE; err_cnt is held.
REQ-033 abort=1 in LOAD or RUN -> IDLE next cycle; ld=0 and en=0 in that cycle; done is not pulsed.
REQ-034 abort has priority over every other transition, including the same-cycle start in IDLE (start is ignored).
REQ-035 start is ignored outside IDLE; latched values do not change during a sequence.
REQ-036 load_val == term_val: RUN has en=0 on its first cycle, and done pulses 2 cycles after LOAD.
REQ-037 Latency start -> ld is 1 cycle; an N-step sequence asserts done N+3 cycles after start is sampled.

Reset
REQ-038 reset=1 at a clock edge -> IDLE regardless of state, including mid-sequence and ERR.
REQ-039 Values after reset: ld=0, en=0, up=0, load_data=0, busy=0, done=0, err=0, err_cnt=0, chk_vld=0, latched registers 0.
REQ-040 reset has priority over abort and start.

Verification
REQ-041 Up run: start, up_dn=1, load_val=3, term_val=7, counter model correct -> ld one cycle, en for 4 cycles, done 7 cycles after start, err=0.
REQ-042 Down wrap: up_dn=0, load_val=1, term_val=14, correct model -> steps 1,0,15,14, no error, done pulses.
REQ-043 Fault: model skips a value twice in an up run (MAX_ERR=3) -> err_cnt=2, err=1, done pulses; three faults -> ERR, en=0, busy=1 until abort.
REQ-044 Equal values: load_val=term_val=9 -> en never asserted, done 2 cycles after ld.
REQ-045 Abort and reset: abort in the 2nd RUN cycle -> IDLE, no done; reset in ERR -> all outputs 0 the next cycle; start while busy is ignored.
